// File: rtl/axi_bram_slave.sv
// axi_bram_slave: single-beat AXI slave backed by an on-chip word memory.
// The read and write channels run independent three-state FSMs. Every
// response is a single beat with s_rlast tied high.
// Optional feature macro: AXI_BRAM_SLAVE_RANGE_CHECK_EN
//   defined   -> addresses outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4) get SLVERR
//   undefined -> the word index wraps modulo DEPTH_WORDS and aliases with OKAY
module axi_bram_slave #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic [7:0]  s_awlen,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [7:0]  s_arlen,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rlast
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP}      r_state_t;
    typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP}  w_state_t;

    // Word storage; contents survive reset.
    logic [31:0] mem [DEPTH_WORDS];

    // Address decode: byte offset from the base, then word index.
    logic [31:0]   ar_off;
    logic [31:0]   aw_off;
    logic [AW-1:0] ar_idx;
    logic [AW-1:0] aw_idx;
    logic          ar_ok;
    logic          aw_ok;
    logic          unused_addr_bits;

    assign ar_off = s_araddr - BASE_ADDR;
    assign aw_off = s_awaddr - BASE_ADDR;
    assign ar_idx = ar_off[AW+1:2];
    assign aw_idx = aw_off[AW+1:2];
    // Byte-lane and wrap-around bits do not select a word.
    assign unused_addr_bits = ^{ar_off[31:AW+2], ar_off[1:0],
                                aw_off[31:AW+2], aw_off[1:0]};

`ifdef AXI_BRAM_SLAVE_RANGE_CHECK_EN
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] off);
        return (addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    endfunction

    assign ar_ok = (s_arlen == 8'd0) && in_range(s_araddr, ar_off);
    assign aw_ok = (s_awlen == 8'd0) && in_range(s_awaddr, aw_off);
`else
    assign ar_ok = (s_arlen == 8'd0);
    assign aw_ok = (s_awlen == 8'd0);
`endif

    // ---------------- read channel ----------------
    r_state_t      r_state_q;
    logic          arready_q;
    logic          rvalid_q;
    logic [31:0]   rdata_q;
    logic [1:0]    rresp_q;
    logic [AW-1:0] r_idx_q;
    logic          r_ok_q;

    // Read FSM: accept address, fetch the word, hold the response until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            r_idx_q   <= '0;
            r_ok_q    <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (s_arvalid) begin
                        r_idx_q   <= ar_idx;
                        r_ok_q    <= ar_ok;
                        arready_q <= 1'b0;
                        r_state_q <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    // Non-blocking read: a same-cycle commit is not yet visible.
                    rdata_q   <= r_ok_q ? mem[r_idx_q] : 32'h0;
                    rresp_q   <= r_ok_q ? OKAY : SLVERR;
                    rvalid_q  <= 1'b1;
                    r_state_q <= R_RESP;
                end
                R_RESP: begin
                    if (s_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: begin
                    rvalid_q  <= 1'b0;
                    arready_q <= 1'b1;
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // ---------------- write channel ----------------
    w_state_t      w_state_q;
    logic          awready_q;
    logic          wready_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;
    logic [AW-1:0] w_idx_q;
    logic          w_ok_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          aw_take;
    logic          w_take;

    // A channel is "held" once its ready has dropped in W_COLLECT.
    assign aw_take = s_awvalid && awready_q;
    assign w_take  = s_wvalid && wready_q;

    // Write FSM: collect AW and W in any order, commit, then respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_COLLECT;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            w_idx_q   <= '0;
            w_ok_q    <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (w_state_q)
                W_COLLECT: begin
                    if (aw_take) begin
                        w_idx_q   <= aw_idx;
                        w_ok_q    <= aw_ok;
                        awready_q <= 1'b0;
                    end
                    if (w_take) begin
                        wdata_q  <= s_wdata;
                        wstrb_q  <= s_wstrb;
                        wready_q <= 1'b0;
                    end
                    if ((aw_take || !awready_q) && (w_take || !wready_q)) begin
                        w_state_q <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    bvalid_q  <= 1'b1;
                    bresp_q   <= w_ok_q ? OKAY : SLVERR;
                    w_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (s_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_COLLECT;
                    end
                end
                default: begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    w_state_q <= W_COLLECT;
                end
            endcase
        end
    end

    // Memory write port: byte-masked update during W_COMMIT for legal requests.
    always_ff @(posedge clk) begin
        if (w_state_q == W_COMMIT && w_ok_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[w_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign s_rlast   = 1'b1;
    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;

endmodule
